// File: rtl/mips_pkg.sv
// Shared MIPS memory-stage definitions: load/store opcodes, LSU state encoding
// and access sizes.
package mips_pkg;

  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a little-endian word bus: byte enables and replicated
// write data for stores, zero-extended lane extraction for loads.
module lsu_lane_align
  import mips_pkg::*;
(
  input  lsu_size_t   size,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  always_comb begin
    mem_be    = 4'b1111;
    wdata     = store_data;
    load_data = mem_rdata;
    case (size)
      SZ_BYTE: begin
        mem_be    = 4'b0001 << lane;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'b0, mem_rdata[{lane, 3'b000} +: 8]};
      end
      // Halfword accesses are already known to be aligned, so only lane[1] matters.
      SZ_HALF: begin
        mem_be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {16'b0, (lane[1] ? mem_rdata[31:16] : mem_rdata[15:0])};
      end
      default: begin
        mem_be    = 4'b1111;
        wdata     = store_data;
        load_data = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS memory-access stage: one load or store per request over a ready
// handshake, with alignment checking, opcode checking and a wait timeout.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] base,
  input  logic [15:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic        illegal_op
);

  lsu_state_t       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [4:0]       dest_q, dest_d;
  logic [1:0]       lane_q, lane_d;
  lsu_size_t        size_q, size_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_reg_q, wb_reg_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             addr_err_q, addr_err_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q, illegal_d;

  logic             op_legal, op_load, misaligned;
  lsu_size_t        op_size, al_size;
  logic [31:0]      ea;
  logic [1:0]       al_lane;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata, al_load;

  assign ea = base + {{16{offset[15]}}, offset};

  always_comb begin
    op_legal = 1'b1;
    op_load  = 1'b0;
    op_size  = SZ_WORD;
    case (opcode)
      OP_LBU:  begin op_load = 1'b1; op_size = SZ_BYTE; end
      OP_LHU:  begin op_load = 1'b1; op_size = SZ_HALF; end
      OP_LW:   begin op_load = 1'b1; op_size = SZ_WORD; end
      OP_SB:   op_size = SZ_BYTE;
      OP_SH:   op_size = SZ_HALF;
      OP_SW:   op_size = SZ_WORD;
      default: op_legal = 1'b0;
    endcase
  end

  assign misaligned = ((op_size == SZ_HALF) && ea[0]) ||
                      ((op_size == SZ_WORD) && (ea[1:0] != 2'b00));

  // One aligner serves both paths: request decode in IDLE, data extraction in ACCESS.
  assign al_size = (state_q == S_ACCESS) ? size_q : op_size;
  assign al_lane = (state_q == S_ACCESS) ? lane_q : ea[1:0];

  lsu_lane_align u_align (
    .size       (al_size),
    .lane       (al_lane),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_be     (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    dest_d      = dest_q;
    lane_d      = lane_q;
    size_d      = size_q;
    load_d      = load_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    wb_en_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;
    illegal_d   = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op_legal || misaligned) begin
            state_d    = S_RESP;
            done_d     = 1'b1;
            illegal_d  = !op_legal;
            addr_err_d = op_legal;
            bus_err_d  = 1'b0;
            wb_reg_d   = dest;
            wb_data_d  = '0;
          end else begin
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = !op_load;
            mem_addr_d  = {ea[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            dest_d      = dest;
            lane_d      = ea[1:0];
            size_d      = op_size;
            load_d      = op_load;
            cnt_d       = '0;
          end
        end
      end
      S_ACCESS: begin
        // A ready arriving on the timeout cycle still completes the access.
        if (mem_ready) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          done_d     = 1'b1;
          wb_en_d    = load_q && (dest_q != 5'd0);
          wb_reg_d   = dest_q;
          wb_data_d  = load_q ? al_load : '0;
          addr_err_d = 1'b0;
          bus_err_d  = 1'b0;
          illegal_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          done_d     = 1'b1;
          wb_reg_d   = dest_q;
          wb_data_d  = '0;
          addr_err_d = 1'b0;
          bus_err_d  = 1'b1;
          illegal_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      dest_q      <= '0;
      lane_q      <= '0;
      size_q      <= SZ_BYTE;
      load_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      dest_q      <= dest_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      illegal_q   <= illegal_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wb_en      = wb_en_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against an arithmetic model of the memory stage.
module tb_load_store_unit;
  import mips_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic [4:0]  dest;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy, done, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        addr_err, bus_err, illegal_op;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .base(base),
    .offset(offset), .store_data(store_data), .dest(dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .addr_err(addr_err), .bus_err(bus_err), .illegal_op(illegal_op)
  );

  typedef struct {
    bit          legal;
    bit          misaligned;
    bit          load;
    int          size;
    int          lane;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } expAcc_t;

  // Reference model: effective address, access size and lane handling by plain arithmetic.
  function automatic expAcc_t modelAccess(input logic [5:0] op, input logic [31:0] b,
                                          input logic [15:0] off, input logic [31:0] sd);
    expAcc_t     e;
    logic [31:0] ea;
    ea = b + 32'($signed(off));
    e.legal = 1; e.load = 0; e.size = 4;
    case (op)
      6'h24: begin e.load = 1; e.size = 1; end
      6'h25: begin e.load = 1; e.size = 2; end
      6'h23: begin e.load = 1; e.size = 4; end
      6'h28: e.size = 1;
      6'h29: e.size = 2;
      6'h2B: e.size = 4;
      default: e.legal = 0;
    endcase
    e.lane       = int'(ea % 4);
    e.misaligned = (ea % e.size) != 0;
    e.addr       = ea - 32'(e.lane);
    e.be         = 4'(((1 << e.size) - 1) << e.lane);
    if (e.size == 1)      e.wdata = (sd & 32'hFF) * 32'h01010101;
    else if (e.size == 2) e.wdata = (sd & 32'hFFFF) * 32'h00010001;
    else                  e.wdata = sd;
    return e;
  endfunction

  function automatic logic [31:0] modelLoad(input expAcc_t e, input logic [31:0] rdata);
    longint unsigned r;
    r = longint'(rdata);
    return 32'((r >> (8 * e.lane)) & ((64'h1 << (8 * e.size)) - 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".mem_req"},  32'(mem_req), 0);
    checkOutput({tag, ".mem_we"},   32'(mem_we), 0);
    checkOutput({tag, ".mem_addr"}, mem_addr, 0);
    checkOutput({tag, ".mem_be"},   32'(mem_be), 0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, ".busy"},     32'(busy), 0);
    checkOutput({tag, ".done"},     32'(done), 0);
    checkOutput({tag, ".wb_en"},    32'(wb_en), 0);
    checkOutput({tag, ".wb_reg"},   32'(wb_reg), 0);
    checkOutput({tag, ".wb_data"},  wb_data, 0);
    checkOutput({tag, ".flags"},    {29'b0, addr_err, bus_err, illegal_op}, 0);
  endtask

  // One complete transaction: issue, optional wait states, completion and return to idle.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] b,
                               input logic [15:0] off, input logic [31:0] sd,
                               input logic [4:0] d, input int waits,
                               input logic [31:0] rdata, input bit pokeStart);
    expAcc_t e;
    bit      success, sawDone, expWb;
    int      reqCycles, expReq;
    e = modelAccess(op, b, off, sd);
    @(negedge clk);
    start = 1; opcode = op; base = b; offset = off; store_data = sd; dest = d;
    @(negedge clk);
    start = 0; base = $urandom; offset = 16'($urandom); store_data = $urandom; dest = 5'($urandom);
    opcode = OP_LW;
    if (!e.legal || e.misaligned) begin
      checkOutput({tag, ".err_done"},    32'(done), 1);
      checkOutput({tag, ".err_req"},     32'(mem_req), 0);
      checkOutput({tag, ".illegal_op"},  32'(illegal_op), 32'(!e.legal));
      checkOutput({tag, ".addr_err"},    32'(addr_err), 32'(e.legal && e.misaligned));
      checkOutput({tag, ".err_bus_err"}, 32'(bus_err), 0);
      checkOutput({tag, ".err_wb_en"},   32'(wb_en), 0);
      checkOutput({tag, ".err_busy"},    32'(busy), 1);
      @(negedge clk);
      checkOutput({tag, ".err_done_clr"}, 32'(done), 0);
      checkOutput({tag, ".err_busy_clr"}, 32'(busy), 0);
      checkOutput({tag, ".err_req_idle"}, 32'(mem_req), 0);
      checkOutput({tag, ".err_hold"},    {30'b0, illegal_op, addr_err},
                  {30'b0, !e.legal, e.legal && e.misaligned});
      return;
    end
    success = (waits <= TO - 1);
    expReq  = success ? waits + 1 : TO;
    expWb   = success && e.load && (d != 0);
    reqCycles = 0;
    sawDone   = 0;
    for (int k = 0; k < TO + 4 && !sawDone; k++) begin
      if (done) begin
        sawDone = 1;
      end else begin
        if (mem_req) reqCycles++;
        checkOutput({tag, ".mem_addr"}, mem_addr, e.addr);
        if (k == 0) begin
          checkOutput({tag, ".mem_req"}, 32'(mem_req), 1);
          checkOutput({tag, ".mem_we"},  32'(mem_we), 32'(!e.load));
          checkOutput({tag, ".mem_be"},  32'(mem_be), 32'(e.be));
          if (!e.load) checkOutput({tag, ".mem_wdata"}, mem_wdata, e.wdata);
          checkOutput({tag, ".busy"},    32'(busy), 1);
        end
        mem_ready = (k == waits);
        mem_rdata = mem_ready ? rdata : $urandom;
        start     = (pokeStart && k == 1);
        if (start) begin opcode = OP_SW; base = 32'h0000_0FF0; offset = 16'h0; end
        @(negedge clk);
      end
    end
    start = 0; mem_ready = 0;
    checkOutput({tag, ".done_seen"}, 32'(sawDone), 1);
    checkOutput({tag, ".req_cycles"}, 32'(reqCycles), 32'(expReq));
    checkOutput({tag, ".bus_err"},  32'(bus_err), 32'(!success));
    checkOutput({tag, ".wb_en"},    32'(wb_en), 32'(expWb));
    checkOutput({tag, ".addr_err"}, 32'(addr_err), 0);
    checkOutput({tag, ".illegal"},  32'(illegal_op), 0);
    checkOutput({tag, ".req_drop"}, 32'(mem_req), 0);
    if (success && e.load) begin
      checkOutput({tag, ".wb_reg"},  32'(wb_reg), 32'(d));
      checkOutput({tag, ".wb_data"}, wb_data, modelLoad(e, rdata));
    end
    @(negedge clk);
    checkOutput({tag, ".done_clr"},  32'(done), 0);
    checkOutput({tag, ".wb_en_clr"}, 32'(wb_en), 0);
    checkOutput({tag, ".busy_clr"},  32'(busy), 0);
    checkOutput({tag, ".idle_req"},  32'(mem_req), 0);
    checkOutput({tag, ".bus_hold"},  32'(bus_err), 32'(!success));
  endtask

  initial begin
    logic [5:0] ops [7];
    ops = '{6'h24, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h20};
    rst_n = 0; start = 0; opcode = 0; base = 0; offset = 0; store_data = 0; dest = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1;

    applyStimulus("lbu",      OP_LBU, 32'h100, 16'h0003, 32'h0,        5'd14, 0, 32'hAABBCCDD, 0);
    checkOutput("lbu.wb_data_const", wb_data, 32'h000000AA);
    applyStimulus("lhu",      OP_LHU, 32'h200, 16'hFFFE, 32'h0,        5'd5,  1, 32'h12345678, 0);
    checkOutput("lhu.wb_data_const", wb_data, 32'h00001234);
    applyStimulus("sh_mis",   OP_SH,  32'h100, 16'h0001, 32'h1234,     5'd3,  0, 32'h0, 0);
    applyStimulus("illegal",  6'h20,  32'h100, 16'h0001, 32'h0,        5'd3,  0, 32'h0, 0);
    applyStimulus("lw_mis",   OP_LW,  32'h102, 16'h0000, 32'h0,        5'd7,  0, 32'h0, 0);
    applyStimulus("sb",       OP_SB,  32'h40,  16'h0002, 32'h000000EE, 5'd9,  3, 32'h0, 1);
    applyStimulus("lw_tmo",   OP_LW,  32'h300, 16'h0000, 32'h0,        5'd4,  10, 32'h0, 0);
    applyStimulus("lw_edge",  OP_LW,  32'h304, 16'h0000, 32'h0,        5'd4,  TO - 1, 32'hCAFEF00D, 0);
    applyStimulus("lw_r0",    OP_LW,  32'h308, 16'h0000, 32'h0,        5'd0,  0, 32'h01020304, 0);
    applyStimulus("sw",       OP_SW,  32'h1000, 16'h8000, 32'hDEADBEEF, 5'd2, 2, 32'h0, 0);
    applyStimulus("sh_hi",    OP_SH,  32'h1002, 16'h0000, 32'h0000ABCD, 5'd2, 0, 32'h0, 0);

    // Reset while an access is outstanding.
    @(negedge clk);
    start = 1; opcode = OP_LW; base = 32'h400; offset = 0; dest = 5'd8;
    @(negedge clk);
    start = 0;
    checkOutput("rst_mid.req_before", 32'(mem_req), 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    checkAllZero("rst_mid");
    rst_n = 1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b = b & 32'hFFFF_FFFC;
      applyStimulus("rand", ops[$urandom_range(0, 6)], b, 16'($urandom_range(0, 7) - 4),
                    $urandom, 5'($urandom), $urandom_range(0, 5), $urandom,
                    $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
